// File: rtl/route_calculator_aco_vc.sv
// Per-VC registered route calculator for one ACO router input port.
// Captures the ant-agent output-port request for each virtual channel on a
// head flit, falls back to the XY route when the ant request is not one-hot,
// and holds the route toward switch control until the tail flit departs.
//
// Ports:
//   i_clk, i_reset_n  clock, asynchronous active-low reset
//   i_val             per-VC head-flit valid (route available this cycle)
//   i_output_req      ant-agent request, VC v at [v*M +: M]
//   i_xy_req          XY fallback request, same packing, one-hot when valid
//   i_release         per-VC tail flit left the switch this cycle
//   o_output_req      held one-hot route per VC, zero when idle
//   o_busy            per-VC route held
//   o_fallback        one-cycle pulse: last capture used i_xy_req
//   o_err_cnt         saturating count of illegal ant requests, all VCs
module route_calculator_aco_vc #(
    parameter int M     = 5,
    parameter int N_VC  = 4,
    parameter int ERR_W = 8
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic [N_VC-1:0]     i_val,
    input  logic [N_VC*M-1:0]   i_output_req,
    input  logic [N_VC*M-1:0]   i_xy_req,
    input  logic [N_VC-1:0]     i_release,
    output logic [N_VC*M-1:0]   o_output_req,
    output logic [N_VC-1:0]     o_busy,
    output logic [N_VC-1:0]     o_fallback,
    output logic [ERR_W-1:0]    o_err_cnt
);

    typedef enum logic {StIdle, StHold} state_e;

    // Wide enough to add up to N_VC errors to a saturated count without overflow.
    localparam int CW = ERR_W + $clog2(N_VC + 1);
    localparam logic [CW-1:0] ErrMax = CW'({ERR_W{1'b1}});

    state_e [N_VC-1:0]   state_q;
    logic [N_VC*M-1:0]   route_q;
    logic [N_VC-1:0]     fallback_q;
    logic [ERR_W-1:0]    err_q;

    logic [N_VC-1:0]     legal;
    logic [N_VC-1:0]     capture;
    logic [N_VC-1:0]     drop;
    logic [CW-1:0]       err_sum;
    logic [ERR_W-1:0]    err_d;

    function automatic logic is_onehot(input logic [M-1:0] x);
        return (x != '0) && ((x & (x - M'(1))) == '0);
    endfunction

    always_comb begin
        legal   = '0;
        capture = '0;
        drop    = '0;
        err_sum = CW'(err_q);
        for (int v = 0; v < N_VC; v++) begin
            legal[v]   = is_onehot(i_output_req[v*M +: M]);
            // A head flit is accepted when idle, or in HOLD only together with
            // the release of the previous packet (back-to-back, no bubble).
            capture[v] = i_val[v] && ((state_q[v] == StIdle) || i_release[v]);
            drop[v]    = (state_q[v] == StHold) && i_release[v] && !i_val[v];
            err_sum    = err_sum + CW'(capture[v] && !legal[v]);
        end
        err_d = (err_sum > ErrMax) ? ErrMax[ERR_W-1:0] : err_sum[ERR_W-1:0];
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int v = 0; v < N_VC; v++) begin
                state_q[v] <= StIdle;
            end
            route_q    <= '0;
            fallback_q <= '0;
            err_q      <= '0;
        end else begin
            for (int v = 0; v < N_VC; v++) begin
                if (capture[v]) begin
                    state_q[v]        <= StHold;
                    route_q[v*M +: M] <= legal[v] ? i_output_req[v*M +: M]
                                                  : i_xy_req[v*M +: M];
                    fallback_q[v]     <= !legal[v];
                end else begin
                    fallback_q[v] <= 1'b0;
                    if (drop[v]) begin
                        state_q[v]        <= StIdle;
                        route_q[v*M +: M] <= '0;
                    end
                end
            end
            err_q <= err_d;
        end
    end

    // Route register is cleared on leaving HOLD, so it drives the output directly.
    always_comb begin
        o_busy = '0;
        for (int v = 0; v < N_VC; v++) begin
            o_busy[v] = (state_q[v] == StHold);
        end
    end

    assign o_output_req = route_q;
    assign o_fallback   = fallback_q;
    assign o_err_cnt    = err_q;

endmodule

// File: tb/tb_route_calculator_aco_vc.sv
// Testbench for route_calculator_aco_vc: table-driven per-cycle vectors plus
// hand-written reset sequences. A second instance with ERR_W=2 shares the
// inputs to exercise counter saturation.
module tb_route_calculator_aco_vc;

    localparam logic [4:0] L = 5'b00001;
    localparam logic [4:0] N = 5'b00010;
    localparam logic [4:0] E = 5'b00100;
    localparam logic [4:0] S = 5'b01000;
    localparam logic [4:0] W = 5'b10000;
    localparam logic [4:0] Z = 5'b00000;

    logic        clk;
    logic        rst_n;
    logic [3:0]  val;
    logic [19:0] oreq;
    logic [19:0] xy;
    logic [3:0]  rel;
    logic [19:0] req_out, req_out_s;
    logic [3:0]  busy, busy_s, fb, fb_s;
    logic [7:0]  err;
    logic [1:0]  err_s;

    int checks = 0;
    int errors = 0;

    route_calculator_aco_vc dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_val        (val),
        .i_output_req (oreq),
        .i_xy_req     (xy),
        .i_release    (rel),
        .o_output_req (req_out),
        .o_busy       (busy),
        .o_fallback   (fb),
        .o_err_cnt    (err)
    );

    route_calculator_aco_vc #(.ERR_W(2)) dut_sat (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_val        (val),
        .i_output_req (oreq),
        .i_xy_req     (xy),
        .i_release    (rel),
        .o_output_req (req_out_s),
        .o_busy       (busy_s),
        .o_fallback   (fb_s),
        .o_err_cnt    (err_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  val;
        logic [19:0] oreq;
        logic [19:0] xy;
        logic [3:0]  rel;
        logic [19:0] req;
        logic [3:0]  busy;
        logic [3:0]  fb;
        logic [7:0]  err;
        logic [1:0]  err_sat;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [19:0] r, input logic [3:0] b,
                           input logic [3:0] f, input logic [7:0] e, input logic [1:0] es);
        chk({tag, " req"}, 32'(req_out), 32'(r));
        chk({tag, " busy"}, 32'(busy), 32'(b));
        chk({tag, " fallback"}, 32'(fb), 32'(f));
        chk({tag, " err"}, 32'(err), 32'(e));
        chk({tag, " err_sat"}, 32'(err_s), 32'(es));
        chk({tag, " sat req"}, 32'(req_out_s), 32'(r));
    endtask

    task automatic drive(input logic [3:0] v, input logic [19:0] o, input logic [19:0] x,
                         input logic [3:0] r);
        val = v; oreq = o; xy = x; rel = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Slice order {vc3, vc2, vc1, vc0}.
        vecs[0]  = '{4'b0001, {Z, Z, Z, E}, {Z, Z, Z, N}, 4'b0000, {Z, Z, Z, E}, 4'b0001, 4'b0000, 8'd0, 2'd0};
        vecs[1]  = '{4'b0000, {Z, Z, Z, Z}, {Z, Z, Z, Z}, 4'b0000, {Z, Z, Z, E}, 4'b0001, 4'b0000, 8'd0, 2'd0};
        vecs[2]  = '{4'b0000, {Z, Z, Z, Z}, {Z, Z, Z, Z}, 4'b0001, {Z, Z, Z, Z}, 4'b0000, 4'b0000, 8'd0, 2'd0};
        vecs[3]  = '{4'b0100, {Z, E|S, Z, Z}, {Z, S, Z, Z}, 4'b0000, {Z, S, Z, Z}, 4'b0100, 4'b0100, 8'd1, 2'd1};
        vecs[4]  = '{4'b0000, {Z, Z, Z, Z}, {Z, Z, Z, Z}, 4'b0000, {Z, S, Z, Z}, 4'b0100, 4'b0000, 8'd1, 2'd1};
        vecs[5]  = '{4'b0000, {Z, Z, Z, Z}, {Z, Z, Z, Z}, 4'b0100, {Z, Z, Z, Z}, 4'b0000, 4'b0000, 8'd1, 2'd1};
        vecs[6]  = '{4'b0100, {Z, Z, Z, Z}, {Z, W, Z, Z}, 4'b0000, {Z, W, Z, Z}, 4'b0100, 4'b0100, 8'd2, 2'd2};
        vecs[7]  = '{4'b0000, {Z, Z, Z, Z}, {Z, Z, Z, Z}, 4'b0100, {Z, Z, Z, Z}, 4'b0000, 4'b0000, 8'd2, 2'd2};
        vecs[8]  = '{4'b0010, {Z, Z, N, Z}, {Z, Z, E, Z}, 4'b0000, {Z, Z, N, Z}, 4'b0010, 4'b0000, 8'd2, 2'd2};
        vecs[9]  = '{4'b0010, {Z, Z, W, Z}, {Z, Z, E, Z}, 4'b0010, {Z, Z, W, Z}, 4'b0010, 4'b0000, 8'd2, 2'd2};
        vecs[10] = '{4'b0000, {Z, Z, Z, Z}, {Z, Z, Z, Z}, 4'b0010, {Z, Z, Z, Z}, 4'b0000, 4'b0000, 8'd2, 2'd2};
        vecs[11] = '{4'b1000, {L, Z, Z, Z}, {N, Z, Z, Z}, 4'b0000, {L, Z, Z, Z}, 4'b1000, 4'b0000, 8'd2, 2'd2};
        // Protocol violations in HOLD: ignored, no error counted.
        vecs[12] = '{4'b1000, {S, Z, Z, Z}, {N, Z, Z, Z}, 4'b0000, {L, Z, Z, Z}, 4'b1000, 4'b0000, 8'd2, 2'd2};
        vecs[13] = '{4'b1000, {Z, Z, Z, Z}, {N, Z, Z, Z}, 4'b0000, {L, Z, Z, Z}, 4'b1000, 4'b0000, 8'd2, 2'd2};
        vecs[14] = '{4'b0000, {Z, Z, Z, Z}, {Z, Z, Z, Z}, 4'b1000, {Z, Z, Z, Z}, 4'b0000, 4'b0000, 8'd2, 2'd2};
        // Release while idle is ignored.
        vecs[15] = '{4'b0000, {Z, Z, Z, Z}, {Z, Z, Z, Z}, 4'b0001, {Z, Z, Z, Z}, 4'b0000, 4'b0000, 8'd2, 2'd2};
        // Four illegal captures at once: 2+4=6, narrow counter saturates at 3.
        vecs[16] = '{4'b1111, {Z, Z, Z, Z}, {L, L, L, L}, 4'b0000, {L, L, L, L}, 4'b1111, 4'b1111, 8'd6, 2'd3};
        vecs[17] = '{4'b1111, {5'h1f, 5'h1f, 5'h1f, 5'h1f}, {E, E, E, E}, 4'b1111,
                     {E, E, E, E}, 4'b1111, 4'b1111, 8'd10, 2'd3};
        vecs[18] = '{4'b0000, {Z, Z, Z, Z}, {Z, Z, Z, Z}, 4'b1111, {Z, Z, Z, Z}, 4'b0000, 4'b0000, 8'd10, 2'd3};

        rst_n = 1'b0;
        drive(4'b0, '0, '0, 4'b0);
        #12;
        chk_all("reset", '0, 4'b0, 4'b0, 8'd0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;

        step();
        chk_all("post reset idle", '0, 4'b0, 4'b0, 8'd0, 2'd0);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].val, vecs[i].oreq, vecs[i].xy, vecs[i].rel);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].req, vecs[i].busy, vecs[i].fb,
                    vecs[i].err, vecs[i].err_sat);
        end

        // Async reset mid-HOLD on every VC, between clock edges.
        drive(4'b1111, {N, N, N, N}, {E, E, E, E}, 4'b0000);
        step();
        chk_all("hold all", {N, N, N, N}, 4'b1111, 4'b0000, 8'd10, 2'd3);
        drive(4'b0, '0, '0, 4'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async reset", '0, 4'b0, 4'b0, 8'd0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_all("after reset idle", '0, 4'b0, 4'b0, 8'd0, 2'd0);
        drive(4'b0001, {Z, Z, Z, S}, {Z, Z, Z, E}, 4'b0000);
        step();
        chk_all("accept after reset", {Z, Z, Z, S}, 4'b0001, 4'b0000, 8'd0, 2'd0);
        drive(4'b0, '0, '0, 4'b0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
